// File: rtl/bus_arbiter.sv
// bus_arbiter: two-port load/store arbiter and sequencer for the shared data bus.
// Grants one master at a time, decodes the address into the IO or data-memory
// window, drives chip-select/strobes for the window's wait states and returns
// read data alongside a one-cycle ready pulse.
// Optional feature: define BUS_ARBITER_ROUND_ROBIN_EN for round-robin grants on
// simultaneous requests; otherwise port 0 has fixed priority.
module bus_arbiter #(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_START_ADDR  = 'h00,
    parameter logic [ADDR_WIDTH-1:0] IO_STOP_ADDR   = 'h3F,
    parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 'h40,
    parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR  = 'hBF,
    parameter int unsigned           MEM_WAIT       = 0,
    parameter int unsigned           IO_WAIT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    inout  logic [DATA_WIDTH-1:0] bus_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  io_cs,
    output logic                  io_we,
    output logic                  io_oe
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    // {mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe}
    logic [5:0]            strb_q, strb_d;
    logic                  drive_q, drive_d;
    logic [1:0]            ready_q, ready_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    logic                  last_q, last_d;
`endif

    logic                  grant1;
    logic                  sel_valid;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] io_off;
    logic [ADDR_WIDTH-1:0] mem_off;
    logic                  in_io;
    logic                  in_mem;

    // Pick the winning port and decode its address into a window.
    // Window test uses the offset from the window start: an address below the
    // start wraps to a large offset, so a single compare covers both bounds.
    always_comb begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        grant1 = req1_valid & (~req0_valid | ~last_q);
`else
        grant1 = req1_valid & ~req0_valid;
`endif
        sel_valid = req0_valid | req1_valid;
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        io_off    = sel_addr - IO_START_ADDR;
        mem_off   = sel_addr - MEM_START_ADDR;
        in_io     = (io_off  <= (IO_STOP_ADDR  - IO_START_ADDR));
        in_mem    = (mem_off <= (MEM_STOP_ADDR - MEM_START_ADDR));
    end

    // Next-state and next-output logic; strobes/ready/err default low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        bus_addr_d = bus_addr_q;
        strb_d     = '0;
        drive_d    = 1'b0;
        ready_d    = '0;
        err_d      = '0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    win_d   = grant1;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                    last_d  = grant1;
`endif
                    if (in_mem) begin
                        state_d    = ST_ACCESS;
                        cnt_d      = 3'(MEM_WAIT);
                        bus_addr_d = mem_off;
                        strb_d     = {1'b1, sel_we, ~sel_we, 3'b000};
                        drive_d    = sel_we;
                    end else if (in_io) begin
                        state_d    = ST_ACCESS;
                        cnt_d      = 3'(IO_WAIT);
                        bus_addr_d = io_off;
                        strb_d     = {3'b000, 1'b1, sel_we, ~sel_we};
                        drive_d    = sel_we;
                    end else begin
                        state_d         = ST_RESP;
                        ready_d[grant1] = 1'b1;
                        err_d[grant1]   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d        = ST_RESP;
                    ready_d[win_q] = 1'b1;
                    if (!we_q) begin
                        if (win_q) rdata1_d = bus_data;
                        else       rdata0_d = bus_data;
                    end
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    strb_d  = strb_q;
                    drive_d = drive_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset releases the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            bus_addr_q <= '0;
            strb_q     <= '0;
            drive_q    <= 1'b0;
            ready_q    <= '0;
            err_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            bus_addr_q <= bus_addr_d;
            strb_q     <= strb_d;
            drive_q    <= drive_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign {mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe} = strb_q;
    assign bus_addr   = bus_addr_q;
    assign bus_data   = drive_q ? wdata_q : 'z;
    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter with a transaction-level
// reference model (grant order, window decode, latency, returned data).
module tb_bus_arbiter;

    localparam int DW         = 8;
    localparam int AW         = 16;
    localparam int MEM_WAIT_C = 0;
    localparam int IO_WAIT_C  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          pend    [2];
    logic          p_we    [2];
    logic [AW-1:0] p_addr  [2];
    logic [DW-1:0] p_wdata [2];

    logic          req0_ready, req1_ready, req0_err, req1_err;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic [AW-1:0] bus_addr;
    wire  [DW-1:0] bus_data;
    logic          mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe;
    logic [DW-1:0] dev_rdata;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            mdl_last;
    logic [DW-1:0] mdl_rdata [2];

    // External memory/IO device: returns dev_rdata while output-enabled.
    assign bus_data = (mem_oe || io_oe) ? dev_rdata : 'z;

    always #5 clk = ~clk;

    bus_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .IO_START_ADDR (16'h0000),
        .IO_STOP_ADDR  (16'h003F),
        .MEM_START_ADDR(16'h0040),
        .MEM_STOP_ADDR (16'h00BF),
        .MEM_WAIT      (MEM_WAIT_C),
        .IO_WAIT       (IO_WAIT_C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(pend[0]),
        .req0_we   (p_we[0]),
        .req0_addr (p_addr[0]),
        .req0_wdata(p_wdata[0]),
        .req0_ready(req0_ready),
        .req0_rdata(req0_rdata),
        .req0_err  (req0_err),
        .req1_valid(pend[1]),
        .req1_we   (p_we[1]),
        .req1_addr (p_addr[1]),
        .req1_wdata(p_wdata[1]),
        .req1_ready(req1_ready),
        .req1_rdata(req1_rdata),
        .req1_err  (req1_err),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .io_cs     (io_cs),
        .io_we     (io_we),
        .io_oe     (io_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe};
    endfunction

    // Window of an address: 0 = none, 1 = IO (0x00..0x3F), 2 = memory (0x40..0xBF).
    function automatic int window_of(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        if (ai >= 'h00 && ai <= 'h3F) return 1;
        if (ai >= 'h40 && ai <= 'hBF) return 2;
        return 0;
    endfunction

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_we[p]    = we;
        p_addr[p]  = a;
        p_wdata[p] = d;
        pend[p]    = 1'b1;
    endtask

    task automatic rand_req(input int p);
        logic [AW-1:0] a;
        if ($urandom_range(0, 7) == 0) a = 16'($urandom);
        else                           a = 16'($urandom_range(0, 255));
        set_req(p, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    // Serve one transaction: must be called with the arbiter idle ahead of the
    // next rising edge. Checks every cycle up to ready, then the idle cycle.
    task automatic serve_one(input bit reissue, input logic [DW-1:0] rdv);
        int            w;
        int            kind;
        int            lat;
        logic [AW-1:0] rel;
        logic [5:0]    exp_strb;
        if (!pend[0] && !pend[1]) return;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        if (pend[0] && pend[1]) w = (mdl_last == 1) ? 0 : 1;
        else                    w = pend[0] ? 0 : 1;
`else
        w = pend[0] ? 0 : 1;
`endif
        mdl_last = w;
        kind = window_of(p_addr[w]);
        rel  = (kind == 2) ? p_addr[w] - 16'h0040 : p_addr[w];
        lat  = (kind == 0) ? 1 : 2 + ((kind == 2) ? MEM_WAIT_C : IO_WAIT_C);
        if (kind == 2)      exp_strb = {1'b1, p_we[w], !p_we[w], 3'b000};
        else if (kind == 1) exp_strb = {3'b000, 1'b1, p_we[w], !p_we[w]};
        else                exp_strb = '0;
        dev_rdata = rdv;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            if (c < lat) begin
                check("access_strobes", 32'(strobes()), 32'(exp_strb));
                check("bus_addr", 32'(bus_addr), 32'(rel));
                if (p_we[w]) check("bus_data_store", 32'(bus_data), 32'(p_wdata[w]));
                check("ready_early", 32'({req1_ready, req0_ready}), 32'd0);
            end else begin
                check("ready_port", 32'({req1_ready, req0_ready}), (w == 1) ? 32'd2 : 32'd1);
                check("err", 32'((w == 1) ? req1_err : req0_err), 32'(kind == 0));
                if (!p_we[w] && kind != 0) mdl_rdata[w] = rdv;
                check("rdata0", 32'(req0_rdata), 32'(mdl_rdata[0]));
                check("rdata1", 32'(req1_rdata), 32'(mdl_rdata[1]));
                check("resp_strobes", 32'(strobes()), 32'd0);
            end
        end
        if (reissue) rand_req(w);
        else         pend[w] = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_resp", 32'({req1_ready, req0_ready, strobes()}), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        dev_rdata    = '0;
        mdl_last     = 1;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p]    = 1'b0;
            p_we[p]    = 1'b0;
            p_addr[p]  = '0;
            p_wdata[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", 32'(strobes()), 32'd0);
        check("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check("reset_err", 32'({req1_err, req0_err}), 32'd0);
        check("reset_rdata", 32'({req1_rdata, req0_rdata}), 32'd0);
        check("reset_bus_addr", 32'(bus_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed: memory load, IO store, decode error, window boundaries.
        set_req(0, 1'b0, 16'h0045, 8'h00);
        serve_one(1'b0, 8'hA5);
        check("mem_load_rdata", 32'(req0_rdata), 32'h0000_00A5);
        set_req(1, 1'b1, 16'h0010, 8'h3C);
        serve_one(1'b0, 8'h00);
        set_req(0, 1'b0, 16'h00C0, 8'h00);
        serve_one(1'b0, 8'h77);
        set_req(1, 1'b0, 16'h003F, 8'h00);
        serve_one(1'b0, 8'h5C);
        set_req(0, 1'b1, 16'h0040, 8'h9E);
        serve_one(1'b0, 8'h00);
        set_req(1, 1'b0, 16'h00BF, 8'h00);
        serve_one(1'b0, 8'hE1);
        set_req(0, 1'b0, 16'h0100, 8'h00);
        serve_one(1'b0, 8'h11);

        // Contention: both ports request continuously for four grants, then drain.
        rand_req(0);
        rand_req(1);
        repeat (4) serve_one(1'b1, 8'($urandom));
        serve_one(1'b0, 8'($urandom));
        serve_one(1'b0, 8'($urandom));

        // Reset during the second IO ACCESS cycle of a port 1 load.
        set_req(1, 1'b0, 16'h0020, 8'h00);
        dev_rdata = 8'h5A;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_io_cs", 32'(io_cs), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_strobes", 32'(strobes()), 32'd0);
        check("async_reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
        pend[1] = 1'b0;
        @(negedge clk);
        check("mid_reset_rdata", 32'({req1_rdata, req0_rdata}), 32'd0);
        check("mid_reset_bus_addr", 32'(bus_addr), 32'd0);
        reset        = 1'b0;
        mdl_last     = 1;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        set_req(0, 1'b0, 16'h0050, 8'h00);
        serve_one(1'b0, 8'hC3);

        // Randomized traffic on one or both ports.
        for (int i = 0; i < 40; i++) begin
            int mask;
            mask = $urandom_range(1, 3);
            if (mask[0]) rand_req(0);
            if (mask[1]) rand_req(1);
            serve_one(1'b0, 8'($urandom));
            serve_one(1'b0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port arbiter and sequencer for the shared data bus. Accepts load/store requests from two masters (port 0: CPU bus interface, port 1: DMA/debug master), grants one at a time, decodes the address into the IO or data-memory window, drives the chip-select and strobe lines for a configurable number of wait states, and returns read data with a one-cycle completion pulse. Sits between the masters and the external memory/IO devices.

## Interface
Parameters:
- DATA_WIDTH, 8, data bus width
- ADDR_WIDTH, 16, address width
- IO_START_ADDR, 8'h00, first IO address
- IO_STOP_ADDR, 8'h3F, last IO address
- MEM_START_ADDR, 8'h40, first data-memory address
- MEM_STOP_ADDR, 8'hBF, last data-memory address
- MEM_WAIT, 0, extra ACCESS cycles for memory (0..7)
- IO_WAIT, 1, extra ACCESS cycles for IO (0..7)

Ports:
- clk  in  1  clock; one clock domain, everything on rising edge
- reset  in  1  asynchronous, active-high
- reqN_valid  in  1  request from port N (N = 0, 1); held until reqN_ready
- reqN_we  in  1  1 = store, 0 = load
- reqN_addr  in  ADDR_WIDTH  absolute address
- reqN_wdata  in  DATA_WIDTH  store data
- reqN_ready  out  1  one-cycle completion pulse
- reqN_rdata  out  DATA_WIDTH  load data, valid while reqN_ready
- reqN_err  out  1  address decode failure, valid while reqN_ready
- bus_addr  out  ADDR_WIDTH  address relative to selected window
- bus_data  inout  DATA_WIDTH  driven only during store ACCESS, else Z
- mem_cs, mem_we, mem_oe  out  1  data-memory select/strobes
- io_cs, io_we, io_oe  out  1  IO select/strobes

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any reqN_valid, pick winner (see Configuration), latch its addr/we/wdata, decode, load wait counter with MEM_WAIT or IO_WAIT, go ACCESS. Address in neither window: skip ACCESS, go RESP with err=1.
- Decode ranges inclusive. bus_addr = addr - MEM_START_ADDR (memory) or addr - IO_START_ADDR (IO).
- ACCESS: selected cs = 1; we = latched we; oe = !we; bus_data driven with latched wdata on store. Counter decrements each cycle; at edge with counter == 0, capture bus_data into winner's rdata (loads only), go RESP.
- RESP: winner's reqN_ready = 1 for exactly one cycle, err as decoded; all cs/we/oe = 0; valid inputs ignored; go IDLE.
- Loser's valid stays pending; served on a later IDLE.
- Strobes 0 (not X) whenever not in ACCESS; never both cs active.
- reqN_rdata holds last captured value until next load completes on that port.
- Reset values: state IDLE, all cs/we/oe 0, bus_addr 0, bus_data Z, reqN_ready 0, reqN_rdata 0, reqN_err 0, last-grant = port 1.

## Timing
- All outputs registered.
- Latency valid-seen (IDLE edge at cycle 0) to ready: memory 2 + MEM_WAIT cycles, IO 2 + IO_WAIT cycles, decode error 1 cycle.
- ACCESS lasts 1 + WAIT cycles; read data sampled on its final edge.
- Minimum request spacing per arbiter: one idle cycle after RESP (IDLE evaluates next edge).
- Valid dropped before ready: undefined; masters must hold.
- Reset mid-ACCESS: strobes drop and bus_data releases immediately (async); no ready pulse issued; request lost.

## Configuration
- BUS_ARBITER_ROUND_ROBIN_EN defined: on simultaneous requests grant the port not granted last; last-grant updates on each grant; reset value makes port 0 win first.
- Undefined: fixed priority, port 0 always wins; last-grant register not implemented.

## Test plan
- Port 0 load addr 16'h0045, mem returns 8'hA5, MEM_WAIT=0 -> mem_cs/oe high 1 cycle, bus_addr 16'h0005, req0_ready at cycle 2, req0_rdata 8'hA5, err 0.
- Port 1 store 8'h3C to 16'h0010, IO_WAIT=1 -> io_cs/io_we high 2 cycles, bus_data 8'h3C, bus_addr 16'h0010, req1_ready at cycle 3.
- Both valid continuously, round-robin enabled -> grants 0,1,0,1; fixed priority -> port 1 starved while port 0 valid.
- Access to 16'h00C0 -> no cs asserted, reqN_ready at cycle 1 with err 1, rdata unchanged.
- Reset asserted in second IO ACCESS cycle -> io_cs 0 and bus_data Z same cycle, no ready pulse, first post-reset request to port 0 completes normally.
